writeback_stage: RTL

Final pipeline stage of the processor: holds the MEM/WB pipeline register, waits for load data from data memory, and drives the register file write port (`writeAddress`, `dataToSave`, `writeEnable`). It is the write-side counterpart of the decode stage's register-file reads. Writes to R15 are diverted to the fetch stage as a PC redirect. It also exports a forwarding tap and a retired-instruction counter.

---
 rtl/writeback_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, load wait, register file and PC write-back
module writeback_stage #(
  parameter int WIDTH        = 8,
  parameter int ADDRESSWIDTH = 4,
  parameter int OPCODEWIDTH  = 4,
  parameter int LOADTIMEOUT  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inValid,
  input  logic [OPCODEWIDTH-1:0]  inOpcode,
  input  logic [ADDRESSWIDTH-1:0] inDestAddress,
  input  logic                    inWritesReg,
  input  logic                    inIsLoad,
  input  logic [WIDTH-1:0]        aluResult,
  input  logic                    loadValid,
  input  logic [WIDTH-1:0]        loadData,
  input  logic                    flush,
  output logic                    stall,
  output logic                    writeEnable,
  output logic [ADDRESSWIDTH-1:0] writeAddress,
  output logic [WIDTH-1:0]        dataToSave,
  output logic                    pcWriteEnable,
  output logic [WIDTH-1:0]        pcTarget,
  output logic                    loadError,
  output logic [OPCODEWIDTH-1:0]  wbOpcode,
  output logic [15:0]             retireCount
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] WRITE     = 2'd2;

  localparam int CW = (LOADTIMEOUT > 2) ? $clog2(LOADTIMEOUT) : 1;
  localparam logic [CW-1:0]           CNTLAST = CW'(LOADTIMEOUT - 1);
  localparam logic [ADDRESSWIDTH-1:0] PCADDR  = ADDRESSWIDTH'(15);

  logic [1:0]              state;
  logic [CW-1:0]           wait_cnt;
  logic [ADDRESSWIDTH-1:0] dest_q;
  logic                    writes_q;
  logic [OPCODEWIDTH-1:0]  op_q;
  logic [WIDTH-1:0]        data_q;
  logic                    err_q;
  logic [15:0]             retire_q;
  logic                    active;

  // State, latched instruction fields, load timeout, error pulse and retire counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      dest_q   <= '0;
      writes_q <= 1'b0;
      op_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      retire_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (flush) begin
        // flush beats capture, load completion, timeout and retirement
        state <= IDLE;
      end else begin
        if (state == WRITE) begin
          retire_q <= retire_q + 16'd1;
        end
        case (state)
          LOAD_WAIT: begin
            if (loadValid) begin
              data_q <= loadData;
              state  <= WRITE;
            end else if (wait_cnt == CNTLAST) begin
              state <= IDLE;
              err_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: begin
            // IDLE and WRITE both accept a new instruction, giving one per cycle
            if (inValid) begin
              dest_q   <= inDestAddress;
              writes_q <= inWritesReg;
              op_q     <= inOpcode;
              if (inIsLoad) begin
                wait_cnt <= '0;
                state    <= LOAD_WAIT;
              end else begin
                data_q <= aluResult;
                state  <= WRITE;
              end
            end else begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  // Strobes decode from the registered state; a flush in WRITE cancels them
  assign active        = (state == WRITE) && !flush;
  assign stall         = (state == LOAD_WAIT);
  assign writeEnable   = active && writes_q && (dest_q != PCADDR);
  assign pcWriteEnable = active && writes_q && (dest_q == PCADDR);
  assign writeAddress  = writeEnable   ? dest_q : '0;
  assign dataToSave    = writeEnable   ? data_q : '0;
  assign pcTarget      = pcWriteEnable ? data_q : '0;
  assign wbOpcode      = active ? op_q : '0;
  assign loadError     = err_q;
  assign retireCount   = retire_q;

endmodule
